// File: rtl/mem_system_ctrl_pkg.sv
// Shared definitions for the two-way cache miss-handling controller.
// Holds the controller state encoding, the CPU address field layout and the
// default line size / memory latency used by the controller and its bench.
package mem_system_ctrl_pkg;

  // Address layout: tag=[15:11], index=[10:3], offset=[2:0]
  localparam int TAG_W   = 5;
  localparam int IDX_W   = 8;
  localparam int OFF_W   = 3;
  localparam int TAG_LSB = IDX_W + OFF_W;
  localparam int IDX_LSB = OFF_W;

  // Words per cache line and backing memory read latency
  localparam int WORDS_DEF   = 4;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RETRY
  } state_t;

endpackage

// File: rtl/mem_system_ctrl_victim_select.sv
// Replacement decision for the two cache ways.
// Owns the round-robin victim flop, which flips on every accepted legal CPU
// request, and picks the way to evict: an invalid way is always preferred,
// otherwise the flop decides.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   advance    - a legal request was accepted this cycle; flip the flop
//   way_valid  - valid bits of the indexed line in each way (bit0 = way0)
//   chosen     - way to use as the victim if this access misses
module mem_system_ctrl_victim_select (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic [1:0] way_valid,
  output logic       chosen
);

  logic victim;

  always_ff @(posedge clk) begin
    if (rst) begin
      victim <= 1'b0;
    end else if (advance) begin
      victim <= ~victim;
    end
  end

  // Filling an empty way never costs a writeback, so empty ways win.
  always_comb begin
    if (!way_valid[0]) begin
      chosen = 1'b0;
    end else if (!way_valid[1]) begin
      chosen = 1'b1;
    end else begin
      chosen = victim;
    end
  end

endmodule

// File: rtl/mem_system_ctrl.sv
// Miss-handling controller for two direct-mapped cache ways in front of a
// banked, pipelined backing memory. Hits complete in the request cycle; a miss
// picks a victim way, writes it back if dirty, refills the line from memory
// and then replays the original access.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   addr, data_in, rd, wr         - CPU request (held while stall is high)
//   data_out, done, stall         - CPU response / busy indication
//   cache_hit, err                - hit without miss handling / error flag
//   way_en, way_write, c_*        - shared command bus to both cache ways
//   way_hit/dirty/valid/err/tag/data - per-way status returned by the ways
//   mem_addr, mem_wdata, mem_rd, mem_wr - backing memory request
//   mem_data_out, mem_stall, mem_err    - backing memory response
module mem_system_ctrl
  import mem_system_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int WORDS   = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        cache_hit,
  output logic        err,
  output logic [1:0]  way_en,
  output logic [1:0]  way_write,
  output logic        c_comp,
  output logic [4:0]  c_tag,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [15:0] c_data,
  output logic        c_valid_in,
  input  logic [1:0]  way_hit,
  input  logic [1:0]  way_dirty,
  input  logic [1:0]  way_valid,
  input  logic [1:0]  way_err,
  input  logic [9:0]  way_tag,
  input  logic [31:0] way_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall,
  input  logic        mem_err
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [CNT_W:0]   NUM_WORDS = (CNT_W + 1)'(WORDS);

  state_t state, next_state;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_offset;

  logic [CNT_W-1:0]   wb_cnt;
  logic [CNT_W:0]     iss_cnt;
  logic [CNT_W-1:0]   ret_cnt;
  logic [MEM_LAT-1:0] ret_sr;
  logic               victim_way;
  logic [TAG_W-1:0]   victim_tag;

  logic illegal_req;
  logic legal_req;
  logic any_hit;
  logic chosen_way;
  logic chosen_dirty;
  logic issuing;
  logic issue_go;
  logic ret_valid;

  assign req_tag    = addr[TAG_LSB +: TAG_W];
  assign req_index  = addr[IDX_LSB +: IDX_W];
  assign req_offset = addr[OFF_W-1:0];

  // Odd byte offsets are illegal for a 16-bit word access.
  assign illegal_req  = (rd & wr) | ((rd | wr) & addr[0]);
  assign legal_req    = (rd ^ wr) & ~addr[0];
  assign any_hit      = |(way_hit & way_valid);
  assign chosen_dirty = way_valid[chosen_way] & way_dirty[chosen_way];

  assign issuing   = (state == FILL) && (iss_cnt < NUM_WORDS);
  assign issue_go  = issuing & ~mem_stall;
  assign ret_valid = ret_sr[MEM_LAT-1];

  mem_system_ctrl_victim_select u_victim_select (
    .clk       (clk),
    .rst       (rst),
    .advance   ((state == IDLE) & legal_req),
    .way_valid (way_valid),
    .chosen    (chosen_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Word counters, the victim captured at miss time, and the return-tracking
  // shift register. The victim tag is captured from the compare access so the
  // writeback addresses do not depend on the way's tag output during WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt     <= '0;
      iss_cnt    <= '0;
      ret_cnt    <= '0;
      ret_sr     <= '0;
      victim_way <= 1'b0;
      victim_tag <= '0;
    end else begin
      ret_sr[0] <= issue_go;
      for (int i = 1; i < MEM_LAT; i++) begin
        ret_sr[i] <= ret_sr[i-1];
      end
      case (state)
        IDLE: begin
          wb_cnt  <= '0;
          iss_cnt <= '0;
          ret_cnt <= '0;
          if (legal_req && !any_hit) begin
            victim_way <= chosen_way;
            victim_tag <= chosen_way ? way_tag[2*TAG_W-1:TAG_W] : way_tag[TAG_W-1:0];
          end
        end
        WB: begin
          if (!mem_stall) begin
            wb_cnt <= wb_cnt + 1'b1;
          end
        end
        FILL: begin
          if (issue_go) begin
            iss_cnt <= iss_cnt + 1'b1;
          end
          if (ret_valid) begin
            ret_cnt <= ret_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and every output. Outputs are forced low while reset is
  // applied so nothing reaches the ways or memory in that cycle, including
  // data still returning from reads issued before the reset.
  always_comb begin
    next_state = state;
    data_out   = '0;
    done       = 1'b0;
    stall      = 1'b0;
    cache_hit  = 1'b0;
    err        = 1'b0;
    way_en     = '0;
    way_write  = '0;
    c_comp     = 1'b0;
    c_tag      = '0;
    c_index    = '0;
    c_offset   = '0;
    c_data     = '0;
    c_valid_in = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;

    if (!rst) begin
      stall = (state != IDLE);
      err   = (|way_err) | mem_err;

      case (state)
        IDLE: begin
          if (illegal_req) begin
            err  = 1'b1;
            done = 1'b1;
          end else if (rd || wr) begin
            way_en    = 2'b11;
            way_write = {wr, wr};
            c_comp    = 1'b1;
            c_tag     = req_tag;
            c_index   = req_index;
            c_offset  = req_offset;
            c_data    = data_in;
            data_out  = (way_hit[1] & way_valid[1]) ? way_data[31:16] : way_data[15:0];
            if (any_hit) begin
              done      = 1'b1;
              cache_hit = 1'b1;
            end else begin
              next_state = chosen_dirty ? WB : FILL;
            end
          end
        end

        WB: begin
          way_en[victim_way] = 1'b1;
          c_index   = req_index;
          c_offset  = {wb_cnt, 1'b0};
          mem_wr    = 1'b1;
          mem_addr  = {victim_tag, req_index, wb_cnt, 1'b0};
          mem_wdata = victim_way ? way_data[31:16] : way_data[15:0];
          if (!mem_stall && wb_cnt == LAST_WORD) begin
            next_state = FILL;
          end
        end

        FILL: begin
          if (issuing) begin
            mem_rd   = 1'b1;
            mem_addr = {req_tag, req_index, iss_cnt[CNT_W-1:0], 1'b0};
          end
          if (ret_valid) begin
            way_en[victim_way]    = 1'b1;
            way_write[victim_way] = 1'b1;
            c_valid_in = 1'b1;
            c_tag      = req_tag;
            c_index    = req_index;
            c_offset   = {ret_cnt, 1'b0};
            c_data     = mem_data_out;
            if (ret_cnt == LAST_WORD) begin
              next_state = RETRY;
            end
          end
        end

        RETRY: begin
          way_en     = 2'b11;
          way_write  = {wr, wr};
          c_comp     = 1'b1;
          c_tag      = req_tag;
          c_index    = req_index;
          c_offset   = req_offset;
          c_data     = data_in;
          data_out   = (way_hit[1] & way_valid[1]) ? way_data[31:16] : way_data[15:0];
          done       = 1'b1;
          next_state = IDLE;
        end

        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_system_ctrl.sv
// Directed bench for mem_system_ctrl with a behavioural two-way cache and a
// two-cycle pipelined memory whose untouched words read as (addr>>1)^16'hA5A5.
module tb_mem_system_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, data_in;
  logic        rd, wr;
  logic [15:0] data_out;
  logic        done, stall, cache_hit, err;
  logic [1:0]  way_en, way_write;
  logic        c_comp;
  logic [4:0]  c_tag;
  logic [7:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data;
  logic        c_valid_in;
  logic [1:0]  way_hit, way_dirty, way_valid, way_err;
  logic [9:0]  way_tag;
  logic [31:0] way_data;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_data_out;
  bit          mem_stall;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_system_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .done(done), .stall(stall), .cache_hit(cache_hit), .err(err),
    .way_en(way_en), .way_write(way_write), .c_comp(c_comp), .c_tag(c_tag),
    .c_index(c_index), .c_offset(c_offset), .c_data(c_data), .c_valid_in(c_valid_in),
    .way_hit(way_hit), .way_dirty(way_dirty), .way_valid(way_valid), .way_err(way_err),
    .way_tag(way_tag), .way_data(way_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
    .mem_stall(mem_stall), .mem_err(mem_err)
  );

  // Behavioural cache ways
  logic [4:0]  m_tag   [2][256];
  bit          m_valid [2][256];
  bit          m_dirty [2][256];
  logic [15:0] m_data  [2][256][4];
  int          fill_cnt [2];

  always_comb begin
    way_hit = '0; way_dirty = '0; way_valid = '0; way_tag = '0; way_data = '0;
    for (int w = 0; w < 2; w++) begin
      way_valid[w] = m_valid[w][c_index];
      way_dirty[w] = m_dirty[w][c_index];
      way_tag[5*w +: 5]   = m_tag[w][c_index];
      way_data[16*w +: 16] = m_data[w][c_index][c_offset[2:1]];
      way_hit[w] = way_en[w] & c_comp & m_valid[w][c_index] & (m_tag[w][c_index] == c_tag);
    end
  end

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (way_en[w] && way_write[w]) begin
        if (c_comp) begin
          if (way_hit[w]) begin
            m_data[w][c_index][c_offset[2:1]] <= c_data;
            m_dirty[w][c_index] <= 1'b1;
          end
        end else begin
          m_data[w][c_index][c_offset[2:1]] <= c_data;
          m_tag[w][c_index]   <= c_tag;
          m_valid[w][c_index] <= c_valid_in;
          m_dirty[w][c_index] <= 1'b0;
          fill_cnt[w] <= fill_cnt[w] + 1;
        end
      end
    end
  end

  // Pipelined memory model plus traffic log
  bit          mem_wv [32768];
  logic [15:0] mem_wd [32768];
  bit          pv0, pv1;
  logic [15:0] pa0, pa1;
  logic [16:0] ev_a [256];
  int          ev_n = 0;
  logic [15:0] st_a [16];
  int          st_n = 0;
  bit          stall_plan = 1'b0;
  int          stall_used = 0;

  function automatic logic [15:0] model_word(input logic [15:0] a);
    return mem_wv[a[15:1]] ? mem_wd[a[15:1]] : ({1'b0, a[15:1]} ^ 16'hA5A5);
  endfunction

  assign mem_data_out = pv1 ? model_word(pa1) : 16'h0000;

  always @(posedge clk) begin
    pv0 <= mem_rd && !mem_stall;
    pa0 <= mem_addr;
    pv1 <= pv0;
    pa1 <= pa0;
    if (mem_wr && !mem_stall) begin
      mem_wv[mem_addr[15:1]] <= 1'b1;
      mem_wd[mem_addr[15:1]] <= mem_wdata;
    end
    if ((mem_rd || mem_wr) && !mem_stall) begin
      if (ev_n < 256) ev_a[ev_n] <= {mem_wr, mem_addr};
      ev_n <= ev_n + 1;
    end
    if (mem_rd && mem_stall) begin
      if (st_n < 16) st_a[st_n] <= mem_addr;
      st_n <= st_n + 1;
    end
  end

  // Stalls the memory for three cycles once word 1 of a fill is offered
  always @(negedge clk) begin
    if (!stall_plan) begin
      stall_used <= 0;
      mem_stall  <= 1'b0;
    end else if (mem_rd && mem_addr[2:1] == 2'd1 && stall_used < 3) begin
      stall_used <= stall_used + 1;
      mem_stall  <= 1'b1;
    end else begin
      mem_stall  <= 1'b0;
    end
  end

  // Drives one request and waits for done; lat is the cycle count, -1 on timeout
  task automatic run_req(input logic [15:0] a, input logic [15:0] d, input logic r,
                         input logic w, output int lat, output logic [15:0] rdata,
                         output logic hit, output logic e, output logic st0,
                         output logic st1);
    addr = a; data_in = d; rd = r; wr = w;
    lat = -1; rdata = '0; hit = 1'b0; e = 1'b0; st0 = 1'b0; st1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) st0 = stall;
      if (c == 1) st1 = stall;
      if (done) begin
        rdata = data_out; hit = cache_hit; e = err; lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != -1) begin
      @(posedge clk); #1;
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  int lat;
  logic [15:0] rdata;
  logic hit, e, st0, st1;
  int e0, f0, f1, s0;

  task automatic test_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    way_err = '0; mem_err = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({stall, done, err, cache_hit, mem_rd, mem_wr, way_en, way_write} !== 10'd0) begin
      bad++; $display("[TB] FAIL reset_outputs: got %b expected 0",
                      {stall, done, err, cache_hit, mem_rd, mem_wr, way_en, way_write});
    end
    @(posedge clk); #1;
    addr = 16'h1234; rd = 1'b1;
    @(negedge clk);
    total++;
    if ({done, way_en, mem_rd} !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_blocks_req: got %b expected 0", {done, way_en, mem_rd});
    end
    @(posedge clk); #1;
    rd = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    e0 = ev_n; f0 = fill_cnt[0]; f1 = fill_cnt[1];
    run_req(16'h1234, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if ({st0, st1} !== 2'b01) begin bad++; $display("[TB] FAIL cold_stall: got %b expected 01", {st0, st1}); end
    total++; if (lat !== 7) begin bad++; $display("[TB] FAIL cold_latency: got %0d expected 7", lat); end
    total++; if ({hit, e} !== 2'b00) begin bad++; $display("[TB] FAIL cold_flags: got %b expected 00", {hit, e}); end
    total++; if (rdata !== 16'hACBF) begin bad++; $display("[TB] FAIL cold_data: got %h expected acbf", rdata); end
    total++; if (ev_n - e0 !== 4) begin bad++; $display("[TB] FAIL cold_mem_ops: got %0d expected 4", ev_n - e0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ev_a[e0+i] !== {1'b0, 16'h1230 + 16'(2*i)}) begin
        bad++; $display("[TB] FAIL cold_rd_addr%0d: got %h expected %h", i, ev_a[e0+i], {1'b0, 16'h1230 + 16'(2*i)});
      end
    end
    total++;
    if ({fill_cnt[0] - f0, fill_cnt[1] - f1} !== {32'd4, 32'd0}) begin
      bad++; $display("[TB] FAIL cold_fills: got %0d/%0d expected 4/0", fill_cnt[0] - f0, fill_cnt[1] - f1);
    end
    e0 = ev_n;
    run_req(16'h1234, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if (lat !== 0) begin bad++; $display("[TB] FAIL hit_latency: got %0d expected 0", lat); end
    total++; if ({hit, rdata} !== {1'b1, 16'hACBF}) begin bad++; $display("[TB] FAIL hit_read: got %b/%h expected 1/acbf", hit, rdata); end
    total++; if (ev_n !== e0) begin bad++; $display("[TB] FAIL hit_no_mem: got %0d expected %0d", ev_n, e0); end
  endtask

  task automatic test_write_hit();
    e0 = ev_n;
    run_req(16'h1236, 16'hBEEF, 1'b0, 1'b1, lat, rdata, hit, e, st0, st1);
    total++; if ({lat == 0, hit, e} !== 3'b110) begin bad++; $display("[TB] FAIL write_hit: got lat=%0d hit=%b err=%b expected 0/1/0", lat, hit, e); end
    run_req(16'h1236, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if ({hit, rdata} !== {1'b1, 16'hBEEF}) begin bad++; $display("[TB] FAIL write_readback: got %b/%h expected 1/beef", hit, rdata); end
    total++; if (ev_n !== e0) begin bad++; $display("[TB] FAIL write_no_mem: got %0d expected %0d", ev_n, e0); end
  endtask

  task automatic test_eviction();
    e0 = ev_n; f1 = fill_cnt[1];
    run_req(16'h1A30, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if ({lat == 7, hit, rdata} !== {2'b10, 16'hA8BD}) begin bad++; $display("[TB] FAIL evict_way1_fill: got lat=%0d hit=%b data=%h expected 7/0/a8bd", lat, hit, rdata); end
    total++; if ({ev_n - e0, fill_cnt[1] - f1} !== {32'd4, 32'd4}) begin bad++; $display("[TB] FAIL evict_way1_ops: got %0d/%0d expected 4/4", ev_n - e0, fill_cnt[1] - f1); end
    run_req(16'h1A30, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if ({lat == 0, hit} !== 2'b11) begin bad++; $display("[TB] FAIL evict_way1_hit: got lat=%0d hit=%b expected 0/1", lat, hit); end
    e0 = ev_n; f0 = fill_cnt[0];
    run_req(16'h2230, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if (lat !== 11) begin bad++; $display("[TB] FAIL evict_wb_latency: got %0d expected 11", lat); end
    total++; if ({hit, rdata} !== {1'b0, 16'hB4BD}) begin bad++; $display("[TB] FAIL evict_wb_data: got %b/%h expected 0/b4bd", hit, rdata); end
    total++; if (ev_n - e0 !== 8) begin bad++; $display("[TB] FAIL evict_wb_ops: got %0d expected 8", ev_n - e0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({ev_a[e0+i], ev_a[e0+4+i]} !== {1'b1, 16'h1230 + 16'(2*i), 1'b0, 16'h2230 + 16'(2*i)}) begin
        bad++; $display("[TB] FAIL evict_order%0d: got %h,%h expected %h,%h", i, ev_a[e0+i], ev_a[e0+4+i],
                        {1'b1, 16'h1230 + 16'(2*i)}, {1'b0, 16'h2230 + 16'(2*i)});
      end
    end
    total++; if ({model_word(16'h1230), model_word(16'h1236)} !== {16'hACBD, 16'hBEEF}) begin
      bad++; $display("[TB] FAIL evict_wb_words: got %h,%h expected acbd,beef", model_word(16'h1230), model_word(16'h1236));
    end
    total++; if (fill_cnt[0] - f0 !== 4) begin bad++; $display("[TB] FAIL evict_way0_fills: got %0d expected 4", fill_cnt[0] - f0); end
    e0 = ev_n; f1 = fill_cnt[1];
    run_req(16'h1236, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if ({lat == 7, hit, rdata} !== {2'b10, 16'hBEEF}) begin bad++; $display("[TB] FAIL refetch_dirty_word: got lat=%0d hit=%b data=%h expected 7/0/beef", lat, hit, rdata); end
    total++; if ({ev_n - e0, fill_cnt[1] - f1} !== {32'd4, 32'd4}) begin bad++; $display("[TB] FAIL refetch_ops: got %0d/%0d expected 4/4", ev_n - e0, fill_cnt[1] - f1); end
  endtask

  task automatic test_mem_stall();
    e0 = ev_n; f0 = fill_cnt[0]; f1 = fill_cnt[1]; s0 = st_n;
    stall_plan = 1'b1;
    run_req(16'h0010, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    stall_plan = 1'b0;
    total++; if (lat !== 10) begin bad++; $display("[TB] FAIL stall_latency: got %0d expected 10", lat); end
    total++; if ({hit, rdata} !== {1'b0, 16'hA5AD}) begin bad++; $display("[TB] FAIL stall_data: got %b/%h expected 0/a5ad", hit, rdata); end
    total++; if (st_n - s0 !== 3) begin bad++; $display("[TB] FAIL stall_cycles: got %0d expected 3", st_n - s0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (st_a[s0+i] !== 16'h0012) begin bad++; $display("[TB] FAIL stall_addr_hold%0d: got %h expected 0012", i, st_a[s0+i]); end
    end
    total++; if (ev_n - e0 !== 4) begin bad++; $display("[TB] FAIL stall_rd_count: got %0d expected 4", ev_n - e0); end
    total++; if (ev_a[e0+1] !== {1'b0, 16'h0012}) begin bad++; $display("[TB] FAIL stall_rd_word1: got %h expected 00012", ev_a[e0+1]); end
    total++; if ({fill_cnt[0] - f0, fill_cnt[1] - f1} !== {32'd4, 32'd0}) begin
      bad++; $display("[TB] FAIL stall_fills: got %0d/%0d expected 4/0", fill_cnt[0] - f0, fill_cnt[1] - f1);
    end
  endtask

  task automatic test_illegal();
    e0 = ev_n;
    addr = 16'h1234; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    total++; if ({err, done, way_en, mem_rd, stall} !== 6'b110000) begin
      bad++; $display("[TB] FAIL illegal_rdwr: got %b expected 110000", {err, done, way_en, mem_rd, stall});
    end
    @(posedge clk); #1;
    addr = 16'h1235; wr = 1'b0;
    @(negedge clk);
    total++; if ({err, done, cache_hit, way_en, stall} !== 6'b110000) begin
      bad++; $display("[TB] FAIL illegal_odd: got %b expected 110000", {err, done, cache_hit, way_en, stall});
    end
    @(posedge clk); #1;
    rd = 1'b0;
    @(negedge clk);
    total++; if ({stall, done, ev_n - e0} !== {2'b00, 32'd0}) begin
      bad++; $display("[TB] FAIL illegal_stays_idle: got stall=%b done=%b ops=%0d expected 0/0/0", stall, done, ev_n - e0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err_passthrough();
    way_err = 2'b10;
    @(negedge clk);
    total++; if ({err, done} !== 2'b10) begin bad++; $display("[TB] FAIL err_way: got %b expected 10", {err, done}); end
    @(posedge clk); #1;
    way_err = 2'b00; mem_err = 1'b1;
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_mem: got %b expected 1", err); end
    @(posedge clk); #1;
    mem_err = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    e0 = ev_n; f0 = fill_cnt[0]; f1 = fill_cnt[1];
    addr = 16'h0100; rd = 1'b1; seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (ev_n - e0 >= 2) begin seen = 1'b1; break; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL midfill_reach: got %b expected 1", seen); end
    rst = 1'b1; rd = 1'b0;
    @(negedge clk);
    total++; if ({way_write, mem_rd} !== 3'b000) begin bad++; $display("[TB] FAIL midfill_rst_quiet: got %b expected 000", {way_write, mem_rd}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL midfill_idle: got %b expected 0", stall); end
    repeat (4) @(posedge clk);
    #1;
    total++; if ({fill_cnt[0] - f0, fill_cnt[1] - f1} !== {32'd0, 32'd0}) begin
      bad++; $display("[TB] FAIL midfill_no_late_write: got %0d/%0d expected 0/0", fill_cnt[0] - f0, fill_cnt[1] - f1);
    end
    run_req(16'h0100, 16'h0, 1'b1, 1'b0, lat, rdata, hit, e, st0, st1);
    total++; if ({lat == 7, hit, rdata} !== {2'b10, 16'hA525}) begin
      bad++; $display("[TB] FAIL midfill_reread: got lat=%0d hit=%b data=%h expected 7/0/a525", lat, hit, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_eviction();
    test_mem_stall();
    test_illegal();
    test_err_passthrough();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
